// File: rtl/noc_pkg.sv
// Shared packet definitions for the mesh-router input stage.
package noc_pkg;

    localparam int PKT_W   = 33;
    localparam int ADDR_HI = 32;
    localparam int ADDR_LO = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 25;
    localparam int DATA_HI = 24;
    localparam int DATA_LO = 0;

    localparam logic [3:0] DEF_BCAST_ADDR = 4'hF;

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  opcode;
        logic [24:0] data;
    } pkt_t;

    typedef enum logic {
        ST_IDLE,
        ST_BCAST
    } bc_state_t;

endpackage

// File: rtl/pkt_fifo.sv
// Parameterised synchronous FIFO; head is the oldest stored entry.
module pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/packet_route_buffer.sv
// Router port input stage: buffers packets and steers the head packet
// to the local depacketizer, the crossbar, or both for broadcasts.
module packet_route_buffer
    import noc_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] NODE_ADDR  = 4'h0,
    parameter logic [3:0] BCAST_ADDR = DEF_BCAST_ADDR,
    parameter int         CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PKT_W-1:0]           in_packet,
    output logic                       local_valid,
    input  logic                       local_ready,
    output logic [PKT_W-1:0]           local_packet,
    output logic                       fwd_valid,
    input  logic                       fwd_ready,
    output logic [PKT_W-1:0]           fwd_packet,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           local_cnt,
    output logic [CNT_W-1:0]           fwd_cnt
);

    bc_state_t        state_q, state_d;
    logic             ldone_q, ldone_d;
    logic             fdone_q, fdone_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic             full, empty, push, pop;
    logic [PKT_W-1:0] head_raw;
    pkt_t             head;
    logic             is_local, is_bcast, is_fwd;
    logic             local_hs, fwd_hs;

    pkt_fifo #(
        .DEPTH (DEPTH),
        .W     (PKT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (in_packet),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (occupancy),
        .head  (head_raw)
    );

    assign head         = pkt_t'(head_raw);
    assign local_packet = head_raw;
    assign fwd_packet   = head_raw;
    assign in_ready     = !reset && !full;
    assign push         = in_valid && in_ready;
    assign local_cnt    = lcnt_q;
    assign fwd_cnt      = fcnt_q;

    assign is_local = !empty && (head.addr == NODE_ADDR);
    assign is_bcast = !empty && (head.addr == BCAST_ADDR);
    assign is_fwd   = !empty && !is_local && !is_bcast;

    // Done flags are zero in IDLE, so a fresh broadcast is offered at once.
    assign local_valid = is_local || (is_bcast && !ldone_q);
    assign fwd_valid   = is_fwd || (is_bcast && !fdone_q);
    assign local_hs    = local_valid && local_ready;
    assign fwd_hs      = fwd_valid && fwd_ready;

    always_comb begin
        state_d = ST_IDLE;
        ldone_d = 1'b0;
        fdone_d = 1'b0;
        lcnt_d  = lcnt_q;
        fcnt_d  = fcnt_q;
        pop     = 1'b0;
        unique case (1'b1)
            is_local: pop = local_hs;
            is_fwd:   pop = fwd_hs;
            is_bcast: begin
                pop = (ldone_q || local_hs) && (fdone_q || fwd_hs);
                if (!pop) begin
                    state_d = ST_BCAST;
                    ldone_d = ldone_q || local_hs;
                    fdone_d = fdone_q || fwd_hs;
                end
            end
            default: pop = 1'b0;
        endcase
        if (local_hs && (lcnt_q != '1)) begin
            lcnt_d = lcnt_q + 1'b1;
        end
        if (fwd_hs && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ldone_q <= 1'b0;
            fdone_q <= 1'b0;
            lcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ldone_q <= ldone_d;
            fdone_q <= fdone_d;
            lcnt_q  <= lcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_packet_route_buffer.sv
// Self-checking bench for packet_route_buffer against a queue-based model.
module tb_packet_route_buffer;
    import noc_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [3:0] NODE  = 4'h2;
    localparam logic [3:0] BC    = 4'hF;
    localparam int         CW    = 4;
    localparam int         CMAX  = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PKT_W-1:0]  in_packet = '0;
    logic              local_valid;
    logic              local_ready = 1'b0;
    logic [PKT_W-1:0]  local_packet;
    logic              fwd_valid;
    logic              fwd_ready = 1'b0;
    logic [PKT_W-1:0]  fwd_packet;
    logic [2:0]        occupancy;
    logic [CW-1:0]     local_cnt;
    logic [CW-1:0]     fwd_cnt;

    packet_route_buffer #(
        .DEPTH      (DEPTH),
        .NODE_ADDR  (NODE),
        .BCAST_ADDR (BC),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_packet    (in_packet),
        .local_valid  (local_valid),
        .local_ready  (local_ready),
        .local_packet (local_packet),
        .fwd_valid    (fwd_valid),
        .fwd_ready    (fwd_ready),
        .fwd_packet   (fwd_packet),
        .occupancy    (occupancy),
        .local_cnt    (local_cnt),
        .fwd_cnt      (fwd_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    pkt_t q[$];
    int   m_lcnt, m_fcnt;
    bit   m_ld, m_fd;
    bit   e_lv, e_fv, e_ir;

    typedef struct {
        logic        iv;
        logic [3:0]  a;
        logic [3:0]  op;
        logic [24:0] d;
        logic        lr;
        logic        fr;
        logic        elv;
        logic        efv;
        logic        eir;
        int          eocc;
    } vec_t;

    vec_t tbl[14];

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic pkt_t mk(logic [3:0] a, logic [3:0] op, logic [24:0] d);
        pkt_t p;
        p.addr   = a;
        p.opcode = op;
        p.data   = d;
        return p;
    endfunction

    function automatic void model_clear();
        q.delete();
        m_lcnt = 0;
        m_fcnt = 0;
        m_ld   = 0;
        m_fd   = 0;
    endfunction

    task automatic drive_check(input logic iv, input pkt_t p,
                               input logic lr, input logic fr);
        in_valid    = iv;
        in_packet   = p;
        local_ready = lr;
        fwd_ready   = fr;
        #1;
        e_ir = (q.size() < DEPTH);
        e_lv = 0;
        e_fv = 0;
        if (q.size() > 0) begin
            if (q[0].addr == NODE) begin
                e_lv = 1;
            end else if (q[0].addr == BC) begin
                e_lv = !m_ld;
                e_fv = !m_fd;
            end else begin
                e_fv = 1;
            end
        end
        chk("in_ready", 64'(in_ready), 64'(e_ir));
        chk("local_valid", 64'(local_valid), 64'(e_lv));
        chk("fwd_valid", 64'(fwd_valid), 64'(e_fv));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("local_cnt", 64'(local_cnt), 64'(m_lcnt));
        chk("fwd_cnt", 64'(fwd_cnt), 64'(m_fcnt));
        if (e_lv) chk("local_packet", 64'(local_packet), 64'(q[0]));
        if (e_fv) chk("fwd_packet", 64'(fwd_packet), 64'(q[0]));
    endtask

    task automatic advance();
        bit lhs, fhs;
        pkt_t inp;
        inp = pkt_t'(in_packet);
        @(posedge clk);
        lhs = e_lv && local_ready;
        fhs = e_fv && fwd_ready;
        if (q.size() > 0) begin
            if (q[0].addr == BC) begin
                m_ld = m_ld || lhs;
                m_fd = m_fd || fhs;
                if (m_ld && m_fd) begin
                    void'(q.pop_front());
                    m_ld = 0;
                    m_fd = 0;
                end
            end else if (lhs || fhs) begin
                void'(q.pop_front());
            end
        end
        if (lhs && m_lcnt < CMAX) m_lcnt++;
        if (fhs && m_fcnt < CMAX) m_fcnt++;
        if (in_valid && e_ir) q.push_back(inp);
        @(negedge clk);
    endtask

    task automatic step(input logic iv, input pkt_t p,
                        input logic lr, input logic fr);
        drive_check(iv, p, lr, fr);
        advance();
    endtask

    task automatic do_reset();
        in_valid    = 0;
        local_ready = 0;
        fwd_ready   = 0;
        reset       = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_clear();
    endtask

    initial begin
        tbl[0]  = '{1, NODE, 4'h1, 25'h0000AB, 1, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 4'h0, 4'h0, 25'h0, 1, 0, 1, 0, 1, 1};
        tbl[2]  = '{0, 4'h0, 4'h0, 25'h0, 1, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 4'h5, 4'h3, 25'd1, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, 4'h5, 4'h3, 25'd2, 0, 0, 0, 1, 1, 1};
        tbl[5]  = '{1, 4'h5, 4'h3, 25'd3, 0, 0, 0, 1, 1, 2};
        tbl[6]  = '{1, 4'h5, 4'h3, 25'd4, 0, 0, 0, 1, 1, 3};
        tbl[7]  = '{1, 4'h5, 4'h3, 25'd5, 0, 0, 0, 1, 0, 4};
        tbl[8]  = '{1, 4'h5, 4'h3, 25'd5, 0, 1, 0, 1, 0, 4};
        tbl[9]  = '{1, 4'h5, 4'h3, 25'd5, 0, 1, 0, 1, 1, 3};
        tbl[10] = '{0, 4'h0, 4'h0, 25'h0, 0, 1, 0, 1, 1, 3};
        tbl[11] = '{0, 4'h0, 4'h0, 25'h0, 0, 1, 0, 1, 1, 2};
        tbl[12] = '{0, 4'h0, 4'h0, 25'h0, 0, 1, 0, 1, 1, 1};
        tbl[13] = '{0, 4'h0, 4'h0, 25'h0, 0, 1, 0, 0, 1, 0};

        model_clear();
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_local_valid", 64'(local_valid), 64'(0));
        chk("rst_fwd_valid", 64'(fwd_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // local delivery and forward backpressure
        for (int i = 0; i < 14; i++) begin
            drive_check(tbl[i].iv, mk(tbl[i].a, tbl[i].op, tbl[i].d),
                        tbl[i].lr, tbl[i].fr);
            chk($sformatf("tbl%0d_lv", i), 64'(local_valid), 64'(tbl[i].elv));
            chk($sformatf("tbl%0d_fv", i), 64'(fwd_valid), 64'(tbl[i].efv));
            chk($sformatf("tbl%0d_ir", i), 64'(in_ready), 64'(tbl[i].eir));
            chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].eocc));
            advance();
        end
        chk("tbl_local_cnt", 64'(local_cnt), 64'(1));
        chk("tbl_fwd_cnt", 64'(fwd_cnt), 64'(5));

        // broadcast split: local takes it at once, crossbar three cycles later
        do_reset();
        step(1, mk(BC, 4'h7, 25'h1234567), 0, 0);
        step(0, '0, 1, 0);
        chk("bc_lv_low", 64'(local_valid), 64'(0));
        chk("bc_fv_high", 64'(fwd_valid), 64'(1));
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        chk("bc_occ", 64'(occupancy), 64'(0));
        chk("bc_lcnt", 64'(local_cnt), 64'(1));
        chk("bc_fcnt", 64'(fwd_cnt), 64'(1));

        // push blocked at full even with a pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(1, mk(4'h5, 4'h2, 25'(i + 10)), 0, 0);
        step(1, mk(4'h5, 4'h2, 25'd20), 0, 1);
        chk("full_occ3", 64'(occupancy), 64'(3));
        step(1, mk(4'h5, 4'h2, 25'd20), 0, 0);
        chk("full_occ4", 64'(occupancy), 64'(4));
        for (int i = 0; i < 5; i++) step(0, '0, 0, 1);

        // reset in the middle of a half-done broadcast
        do_reset();
        step(1, mk(BC, 4'h1, 25'h55), 0, 0);
        step(1, mk(4'h5, 4'h1, 25'h66), 0, 0);
        step(1, mk(4'h6, 4'h1, 25'h77), 1, 0);
        chk("mid_occ", 64'(occupancy), 64'(3));
        in_valid = 1;
        #2;
        reset = 1;
        #1;
        chk("mid_rst_ir", 64'(in_ready), 64'(0));
        chk("mid_rst_lv", 64'(local_valid), 64'(0));
        chk("mid_rst_fv", 64'(fwd_valid), 64'(0));
        chk("mid_rst_occ", 64'(occupancy), 64'(0));
        @(negedge clk);
        reset = 0;
        model_clear();
        step(1, mk(NODE, 4'h9, 25'h1ABCDEF), 0, 0);
        step(0, '0, 1, 0);
        chk("post_rst_lcnt", 64'(local_cnt), 64'(1));
        chk("post_rst_fcnt", 64'(fwd_cnt), 64'(0));

        // local counter saturation
        do_reset();
        for (int i = 0; i < 18; i++) step(1, mk(NODE, 4'h4, 25'(i)), 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        chk("sat_lcnt", 64'(local_cnt), 64'(15));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [3:0] a;
            int r;
            r = int'($urandom_range(0, 3));
            case (r)
                0:       a = NODE;
                1:       a = BC;
                2:       a = 4'h5;
                default: a = 4'($urandom);
            endcase
            if (i == 400) do_reset();
            step(($urandom % 3) != 0, mk(a, 4'($urandom), 25'($urandom)),
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/packet_route_buffer.md
Name: packet_route_buffer

Overview:
Clocked input stage of a mesh-router port. It sits directly downstream of a PE/memory packetizer and upstream of the router crossbar and the local depacketizer. It buffers 33-bit packets {addr[32:29], opcode[28:25], data[24:0]} in a small FIFO and steers the head packet by destination address:
- local port (to depacketizer) when addr == NODE_ADDR
- forward port (to crossbar) otherwise
- both ports for the broadcast address

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NODE_ADDR, 4'h0, address of this node.
- BCAST_ADDR, 4'hF, broadcast destination; must differ from NODE_ADDR.
- CNT_W, 16, width of the delivered-packet counters.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Upstream packet valid.
- in_ready  out  1  Buffer can accept a packet.
- in_packet  in  33  Packet {addr, opcode, data}.
- local_valid  out  1  Head packet offered to the local depacketizer.
- local_ready  in  1  Local depacketizer accepts.
- local_packet  out  33  Head packet, local copy.
- fwd_valid  out  1  Head packet offered to the crossbar.
- fwd_ready  in  1  Crossbar accepts.
- fwd_packet  out  33  Head packet, forward copy.
- occupancy  out  $clog2(DEPTH)+1  Entries currently stored.
- local_cnt  out  CNT_W  Packets delivered locally, saturating.
- fwd_cnt  out  CNT_W  Packets forwarded, saturating.

Behaviour:
- Reset (asynchronous assert, released synchronously by the environment) clears:
  - FIFO pointers, occupancy = 0, counters = 0
  - broadcast flags = 0, state = IDLE
  - local_valid = fwd_valid = in_ready = 0
  - in_ready is forced to 0 for as long as reset is high.
  - A reset mid-transfer discards all stored packets, including a partly delivered broadcast.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Each valid is a function of registered state only, never of the matching ready.
  - Once asserted, a valid and its packet hold until accepted.
- in_ready = (occupancy < DEPTH). No push is allowed when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle: occupancy is unchanged; the pointers wrap modulo DEPTH.
- Latency: a packet pushed into an empty buffer at edge k is presented at the head from edge k on, so the earliest consumer acceptance is edge k+1. There is no combinational path from input to output.
- local_packet and fwd_packet both always carry the head entry. Their value is don't-care when the corresponding valid is low.
- Routing of the head packet (FIFO not empty):
  - head.addr == NODE_ADDR: local_valid = 1, fwd_valid = 0. Pop on local handshake.
  - head.addr == BCAST_ADDR: broadcast FSM.
  - Any other address: fwd_valid = 1, local_valid = 0. Pop on fwd handshake.
- Broadcast FSM:
  - States: IDLE, BCAST.
  - IDLE → BCAST when the head is broadcast. local_done and fwd_done are 0 on entry.
  - In BCAST: local_valid = !local_done and fwd_valid = !fwd_done. Each handshake sets its done flag.
  - Pop occurs on the cycle where the last outstanding handshake completes, including both completing in the same cycle. The FSM then returns to IDLE and clears both flags.
  - The FIFO does not advance past a broadcast until both ports have accepted it (head-of-line blocking is intended).
- Counters:
  - local_cnt increments on each local handshake; fwd_cnt increments on each fwd handshake. A broadcast counts once in each.
  - Both saturate at all-ones and never wrap.
- Opcode and data pass through untouched; addr is not rewritten.

Decomposition:
- Shared package noc_pkg contains:
  - PKT_W = 33 and the field bounds (ADDR 32:29, OPCODE 28:25, DATA 24:0)
  - typedef struct packed pkt_t {logic [3:0] addr; logic [3:0] opcode; logic [24:0] data;}
  - default BCAST_ADDR
- One sub-module: pkt_fifo, a parameterised synchronous FIFO with push, pop, full, empty, count and head outputs. Steering, the broadcast FSM and the counters live in packet_route_buffer.

Test Plan:
- Local delivery: NODE_ADDR=2, push {addr=2, op=4'h1, data=25'h0000AB}, local_ready=1. local_valid high one cycle after the push; packet bit-exact; local_cnt=1; fwd_valid never high.
- Forward with backpressure: push addr=5 packets data=1,2,3,4,5 with fwd_ready=0. in_ready drops after the 4th (occupancy=4) and the 5th is held. Then raise fwd_ready: packets exit in order 1..5, fwd_cnt=5.
- Broadcast split: push addr=F, data=25'h1234567. local_ready=1 at cycle 1; fwd_ready=1 only at cycle 4. local_valid falls after cycle 1, fwd_valid stays high to cycle 4, a single pop, both counters = 1.
- Simultaneous push and pop at full: occupancy=4, in_valid=1, fwd_ready=1. in_ready=0 so no push; occupancy goes to 3, then refills to 4 on the next cycle.
- Reset mid-operation: 3 packets stored and broadcast half-done. Assert reset between edges: all valids and in_ready go low immediately; after release, occupancy=0, counters=0, and a new packet is delivered normally.
- Counter saturation: CNT_W=4, deliver 18 local packets → local_cnt holds 4'hF.
